// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int OUT_WIDTH_DEF  = 16;

    // Frame-leading command bytes: OP carries A, B, FUN; NOP carries FUN only.
    localparam logic [7:0] CMD_ALU_OP_DEF  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP_DEF = 8'hDD;

    // Largest function byte accepted. Compared against the whole received
    // byte, so 0x10 is rejected even though its low nibble is 0.
    localparam logic [7:0] FUN_MAX = 8'd14;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_NAND = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_XOR  = 4'd8,
        ALU_XNOR = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_GT   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_SHR  = 4'd13,
        ALU_SHL  = 4'd14
    } alu_op_e;

    // Command-side FSM. TX_RUN covers the whole two-byte return handshake,
    // which is sequenced by tx_byte_seq.
    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_RUN,
        WAIT_RES,
        TX_RUN
    } ctrl_state_e;

    // Return-path FSM inside tx_byte_seq.
    typedef enum logic [2:0] {
        TX_IDLE,
        SEND_LO,
        WAIT_LO_HI,
        WAIT_LO_LO,
        SEND_HI,
        WAIT_HI_HI,
        WAIT_HI_LO
    } tx_state_e;

endpackage

// File: rtl/tx_byte_seq.sv
// Sends a 2*DATA_WIDTH word to the UART transmitter, low byte first.
// Latency: request 2 cycles after start_vld when the transmitter is idle.
// Backpressure: each request waits for tx_busy low; the next byte waits for an observed tx_busy rise and fall.
//
// Ports:
//   CLK, RST        clock, async active-low reset
//   word_dat        word to send, sampled per byte when the request is made
//   start_vld       one-cycle strobe starting a two-byte sequence
//   tx_busy         transmitter serialising flag
//   tx_dat/tx_vld   registered byte and one-cycle request to the transmitter
//   done_vld        combinational strobe in the cycle the sequence completes
module tx_byte_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [2*DATA_WIDTH-1:0]   word_dat,
    input  logic                      start_vld,
    input  logic                      tx_busy,
    output logic [DATA_WIDTH-1:0]     tx_dat,
    output logic                      tx_vld,
    output logic                      done_vld
);

    tx_state_e state_q, state_d;
    logic      send_lo, send_hi;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= TX_IDLE;
            tx_vld  <= 1'b0;
            tx_dat  <= '0;
        end else begin
            state_q <= state_d;
            tx_vld  <= send_lo | send_hi;
            if (send_lo) begin
                tx_dat <= word_dat[DATA_WIDTH-1:0];
            end else if (send_hi) begin
                tx_dat <= word_dat[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    // The WAIT_*_HI states exist because the request is registered: the
    // transmitter only raises tx_busy after seeing it, so we must see the
    // rise before trusting a low tx_busy again.
    always_comb begin
        state_d  = state_q;
        send_lo  = 1'b0;
        send_hi  = 1'b0;
        done_vld = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start_vld) begin
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (!tx_busy) begin
                    send_lo = 1'b1;
                    state_d = WAIT_LO_HI;
                end
            end
            WAIT_LO_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO_LO;
                end
            end
            WAIT_LO_LO: begin
                if (!tx_busy) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!tx_busy) begin
                    send_hi = 1'b1;
                    state_d = WAIT_HI_HI;
                end
            end
            WAIT_HI_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_HI_LO;
                end
            end
            WAIT_HI_LO: begin
                if (!tx_busy) begin
                    done_vld = 1'b1;
                    state_d  = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Parses UART command frames, drives the ALU, and returns its 16-bit result over UART TX, low byte first.
// Latency: ALU_EN 1 cycle after the last frame byte; first TX request 3 cycles after ALU_OUT_VALID if TX idle.
// Backpressure: none on RX (bytes outside parsing states are dropped); TX waits on TX_BUSY.
//
// Ports:
//   CLK, RST                 clock, async active-low reset
//   RX_P_DATA/RX_D_VLD       received byte and its one-cycle strobe
//   ALU_OUT/ALU_OUT_VALID    registered ALU result and its valid flag
//   TX_BUSY                  transmitter serialising flag
//   ALU_A/ALU_B/ALU_FUN      operand and function registers
//   ALU_EN                   one-cycle ALU enable
//   TX_P_DATA/TX_D_VLD       byte and one-cycle request to the transmitter
//   BUSY                     high whenever not idle
//   CMD_ERR                  one-cycle pulse on a rejected byte
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int                    OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = CMD_ALU_OP_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = CMD_ALU_NOP_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  RX_P_DATA,
    input  logic                   RX_D_VLD,
    input  logic [OUT_WIDTH-1:0]   ALU_OUT,
    input  logic                   ALU_OUT_VALID,
    input  logic                   TX_BUSY,
    output logic [DATA_WIDTH-1:0]  ALU_A,
    output logic [DATA_WIDTH-1:0]  ALU_B,
    output alu_op_e                ALU_FUN,
    output logic                   ALU_EN,
    output logic [DATA_WIDTH-1:0]  TX_P_DATA,
    output logic                   TX_D_VLD,
    output logic                   BUSY,
    output logic                   CMD_ERR
);

    localparam logic [DATA_WIDTH-1:0] FUN_LIMIT = DATA_WIDTH'(FUN_MAX);

    ctrl_state_e          state_q, state_d;
    logic [OUT_WIDTH-1:0] result_q;
    logic                 tx_start_q;
    logic                 tx_done;
    logic                 err_d;
    logic                 ld_a, ld_b, ld_fun, cap_res;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FUN    <= ALU_ADD;
            ALU_EN     <= 1'b0;
            BUSY       <= 1'b0;
            CMD_ERR    <= 1'b0;
            result_q   <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            ALU_EN     <= (state_d == ALU_RUN);
            BUSY       <= (state_d != IDLE);
            CMD_ERR    <= err_d;
            tx_start_q <= cap_res;
            if (ld_a) begin
                ALU_A <= RX_P_DATA;
            end
            if (ld_b) begin
                ALU_B <= RX_P_DATA;
            end
            if (ld_fun) begin
                ALU_FUN <= alu_op_e'(RX_P_DATA[3:0]);
            end
            if (cap_res) begin
                result_q <= ALU_OUT;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_fun  = 1'b0;
        cap_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OP) begin
                        state_d = GET_A;
                    end else if (RX_P_DATA == CMD_ALU_NOP) begin
                        state_d = GET_FUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (RX_D_VLD) begin
                    ld_a    = 1'b1;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (RX_D_VLD) begin
                    ld_b    = 1'b1;
                    state_d = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA <= FUN_LIMIT) begin
                        ld_fun  = 1'b1;
                        state_d = ALU_RUN;
                    end else begin
                        // Rejected function: previous ALU_FUN is kept.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ALU_RUN: begin
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (ALU_OUT_VALID) begin
                    cap_res = 1'b1;
                    state_d = TX_RUN;
                end
            end
            TX_RUN: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    tx_byte_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_seq (
        .CLK       (CLK),
        .RST       (RST),
        .word_dat  (result_q),
        .start_vld (tx_start_q),
        .tx_busy   (TX_BUSY),
        .tx_dat    (TX_P_DATA),
        .tx_vld    (TX_D_VLD),
        .done_vld  (tx_done)
    );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed frames plus random frames against a frame-level model.
// Latency: n/a (testbench).
// Backpressure: the UART TX model holds TX_BUSY for a configurable number of cycles per byte.
module tb_alu_cmd_ctrl;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        ALU_OUT_VALID = 1'b0;
    logic        TX_BUSY = 1'b0;
    logic [7:0]  ALU_A, ALU_B;
    alu_op_e     ALU_FUN;
    logic        ALU_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD, BUSY, CMD_ERR;

    alu_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VLD      (RX_D_VLD),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VALID (ALU_OUT_VALID),
        .TX_BUSY       (TX_BUSY),
        .ALU_A         (ALU_A),
        .ALU_B         (ALU_B),
        .ALU_FUN       (ALU_FUN),
        .ALU_EN        (ALU_EN),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VLD      (TX_D_VLD),
        .BUSY          (BUSY),
        .CMD_ERR       (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Observations collected by the environment models.
    int          alu_en_cnt = 0;
    int          cmd_err_cnt = 0;
    int          tx_viol = 0;
    logic [7:0]  seen_a = 8'h00, seen_b = 8'h00;
    logic [3:0]  seen_fun = 4'h0;
    logic [7:0]  tx_q[$];

    // Environment knobs.
    logic [15:0] alu_ret = 16'h0000;
    int          alu_delay = 0;
    int          alu_wait = -1;
    int          tx_hold = 3;
    int          tx_cnt = 0;

    // Frame-level reference state: what the operand/function registers hold.
    logic [7:0]  m_a = 8'h00, m_b = 8'h00;
    logic [3:0]  m_fun = 4'h0;

    // Registered ALU stand-in: answers alu_delay+1 cycles after ALU_EN.
    always @(negedge CLK) begin
        ALU_OUT_VALID = 1'b0;
        if (alu_wait == 0) begin
            ALU_OUT       = alu_ret;
            ALU_OUT_VALID = 1'b1;
            alu_wait      = -1;
        end else if (alu_wait > 0) begin
            alu_wait--;
        end
        if (ALU_EN === 1'b1) begin
            alu_en_cnt++;
            seen_a   = ALU_A;
            seen_b   = ALU_B;
            seen_fun = ALU_FUN;
            alu_wait = alu_delay;
        end
    end

    // UART transmitter stand-in: busy for tx_hold cycles per accepted byte.
    always @(negedge CLK) begin
        if (TX_D_VLD === 1'b1) begin
            if (TX_BUSY === 1'b1) tx_viol++;
            tx_q.push_back(TX_P_DATA);
            TX_BUSY = 1'b1;
            tx_cnt  = tx_hold;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) TX_BUSY = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (CMD_ERR === 1'b1) cmd_err_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/alu_a"},   16'(ALU_A),   16'h0);
        chk({tag, "/alu_b"},   16'(ALU_B),   16'h0);
        chk({tag, "/alu_fun"}, 16'(ALU_FUN), 16'(ALU_ADD));
        chk({tag, "/alu_en"},  16'(ALU_EN),  16'h0);
        chk({tag, "/tx_data"}, 16'(TX_P_DATA), 16'h0);
        chk({tag, "/tx_vld"},  16'(TX_D_VLD), 16'h0);
        chk({tag, "/busy"},    16'(BUSY),    16'h0);
        chk({tag, "/cmd_err"}, 16'(CMD_ERR), 16'h0);
    endtask

    // Sends one frame, predicts its effect from the frame rules, and checks it.
    task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [15:0] ret, input bit inject, input string tag);
        int         n;
        int         k;
        int         en0, err0;
        logic [7:0] fun;
        bit         exp_alu, exp_err;
        exp_alu = 1'b0;
        exp_err = 1'b0;
        fun     = 8'h00;
        if (b0 == 8'hCC) begin
            n = 4; m_a = b1; m_b = b2; fun = b3;
        end else if (b0 == 8'hDD) begin
            n = 2; fun = b1;
        end else begin
            n = 1; exp_err = 1'b1;
        end
        if (!exp_err) begin
            if (fun > 8'd14) exp_err = 1'b1;
            else begin
                exp_alu = 1'b1;
                m_fun   = fun[3:0];
            end
        end

        tx_q.delete();
        en0     = alu_en_cnt;
        err0    = cmd_err_cnt;
        alu_ret = ret;

        send_byte(b0);
        if (n > 1) begin gap(); send_byte(b1); end
        if (n == 4) begin gap(); send_byte(b2); gap(); send_byte(b3); end

        if (exp_alu) begin
            if (inject) begin
                k = 0;
                while (tx_q.size() < 2 && k < 3000) begin
                    @(negedge CLK);
                    RX_P_DATA = 8'hAA;
                    RX_D_VLD  = (k % 3 == 0);
                    k++;
                end
                RX_D_VLD = 1'b0;
            end
            k = 0;
            while (!(tx_q.size() >= 2 && BUSY === 1'b0) && k < 3000) begin
                @(negedge CLK);
                k++;
            end
            chk({tag, "/timeout"}, 16'(k < 3000), 16'h1);
        end else begin
            repeat (4) @(negedge CLK);
        end

        chk({tag, "/en_count"}, 16'(alu_en_cnt - en0), exp_alu ? 16'h1 : 16'h0);
        chk({tag, "/err_count"}, 16'(cmd_err_cnt - err0), exp_err ? 16'h1 : 16'h0);
        chk({tag, "/tx_count"}, 16'(tx_q.size()), exp_alu ? 16'h2 : 16'h0);
        if (exp_alu) begin
            chk({tag, "/en_a"},   16'(seen_a),   16'(m_a));
            chk({tag, "/en_b"},   16'(seen_b),   16'(m_b));
            chk({tag, "/en_fun"}, 16'(seen_fun), 16'(m_fun));
            if (tx_q.size() == 2) begin
                chk({tag, "/tx_lo"}, 16'(tx_q[0]), 16'(ret[7:0]));
                chk({tag, "/tx_hi"}, 16'(tx_q[1]), 16'(ret[15:8]));
            end
        end
        chk({tag, "/alu_a"},   16'(ALU_A),   16'(m_a));
        chk({tag, "/alu_b"},   16'(ALU_B),   16'(m_b));
        chk({tag, "/alu_fun"}, 16'(ALU_FUN), 16'(m_fun));
        chk({tag, "/busy"},    16'(BUSY),    16'h0);
        chk({tag, "/tx_viol"}, 16'(tx_viol), 16'h0);
    endtask

    logic [7:0]  r0, r1, r2, r3;
    logic [15:0] rret;
    bit          rinj;
    int          kind;
    int          w;

    initial begin
        // Reset state.
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        tx_hold = 3; alu_delay = 0;
        do_frame(8'hCC, 8'h12, 8'h34, 8'h00, 16'h0046, 1'b0, "add");
        do_frame(8'hDD, 8'h01, 8'h00, 8'h00, 16'hFFDE, 1'b0, "reuse_sub");

        // Long transmitter hold: the second request must wait for the fall.
        tx_hold = 200;
        do_frame(8'hCC, 8'hFF, 8'hFF, 8'h02, 16'hFE01, 1'b0, "mul");
        tx_hold = 3;

        do_frame(8'h55, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, "bad_cmd");
        do_frame(8'hCC, 8'h01, 8'h02, 8'h0F, 16'h0000, 1'b0, "bad_fun");

        // Stray 0xAA bytes through WAIT_RES and the transmit handshake.
        alu_delay = 3; tx_hold = 4;
        do_frame(8'hCC, 8'h21, 8'h43, 8'h08, 16'hA55A, 1'b1, "inject");
        alu_delay = 0;

        // Reset while waiting for the low byte to finish transmitting.
        tx_hold = 20;
        tx_q.delete();
        alu_ret = 16'hBEEF;
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h06); send_byte(8'h01);
        w = 0;
        while (tx_q.size() < 1 && w < 100) begin @(negedge CLK); w++; end
        chk("rst_mid/first_byte", 16'(tx_q.size()), 16'h1);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        m_a = 8'h00; m_b = 8'h00; m_fun = 4'h0;
        w = 0;
        while (TX_BUSY === 1'b1 && w < 100) begin @(negedge CLK); w++; end
        repeat (5) @(negedge CLK);
        chk("rst_mid/no_hi_byte", 16'(tx_q.size()), 16'h1);
        chk("rst_mid/busy", 16'(BUSY), 16'h0);
        tx_hold = 3;
        do_frame(8'hCC, 8'h03, 8'h04, 8'h00, 16'h0007, 1'b0, "after_rst");

        // Random frames: mix of full, reuse and garbage, with varied timing.
        for (int i = 0; i < 40; i++) begin
            kind      = $urandom_range(0, 9);
            tx_hold   = $urandom_range(1, 5);
            alu_delay = $urandom_range(0, 3);
            rret      = 16'($urandom);
            rinj      = 1'($urandom_range(0, 1));
            r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom_range(0, 18));
            if (kind < 6) begin
                r0 = 8'hCC;
            end else if (kind < 9) begin
                r0 = 8'hDD;
                r1 = 8'($urandom_range(0, 18));
            end else begin
                r0 = 8'($urandom);
                if (r0 == 8'hCC || r0 == 8'hDD) r0 = 8'h00;
            end
            do_frame(r0, r1, r2, r3, rret, rinj, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller for the arithmetic unit in the UART system. It parses command frames arriving byte-by-byte from the UART receiver and drives the ALU operand, function and enable inputs. It captures the registered 16-bit ALU result and returns it to the host through the UART transmitter, low byte first. It is the only master of the ALU and the only producer of TX bytes in this path.

## Interface
- DATA_WIDTH, 8: UART byte and ALU operand width.
- OUT_WIDTH, 16: ALU result width; must equal 2*DATA_WIDTH.
- CMD_ALU_OP, 8'hCC: command byte; frame is CMD, A, B, FUN.
- CMD_ALU_NOP, 8'hDD: command byte; frame is CMD, FUN, reusing the stored A and B.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  8  received byte; valid only while RX_D_VLD is high.
- RX_D_VLD  in  1  one-cycle strobe per received byte.
- ALU_OUT  in  16  registered ALU result.
- ALU_OUT_VALID  in  1  result-valid flag from the ALU.
- TX_BUSY  in  1  high while the UART transmitter is serialising a byte.
- ALU_A  out  8  operand A register.
- ALU_B  out  8  operand B register.
- ALU_FUN  out  alu_op_e  function register.
- ALU_EN  out  1  one-cycle ALU enable.
- TX_P_DATA  out  8  byte to transmit.
- TX_D_VLD  out  1  one-cycle transmit request.
- BUSY  out  1  high in every state except IDLE.
- CMD_ERR  out  1  one-cycle pulse on a rejected byte.

## Operation
- FSM states: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LO, WAIT_LO_HI, WAIT_LO_LO, SEND_HI, WAIT_HI_HI, WAIT_HI_LO.
- IDLE:
  - RX_D_VLD with 0xCC goes to GET_A.
  - RX_D_VLD with 0xDD goes to GET_FUN.
  - Any other byte pulses CMD_ERR and stays in IDLE.
- GET_A and GET_B: on RX_D_VLD, load ALU_A or ALU_B respectively and advance. GET_A goes to GET_B; GET_B goes to GET_FUN.
- GET_FUN, on RX_D_VLD:
  - byte ≤ 14: load ALU_FUN from the low 4 bits and go to ALU_RUN.
  - byte > 14: pulse CMD_ERR, return to IDLE, leave ALU_FUN unchanged, issue no ALU_EN.
- Function encoding: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, NAND=6, NOR=7, XOR=8, XNOR=9, EQ=10, GT=11, LT=12, SHR=13, SHL=14.
- ALU_RUN: ALU_EN high for exactly this cycle; go to WAIT_RES.
- WAIT_RES: when ALU_OUT_VALID is high, capture ALU_OUT into a 16-bit result register and go to SEND_LO.
- SEND_LO:
  - Wait until TX_BUSY is low.
  - Then drive TX_P_DATA = result[7:0] with TX_D_VLD high for one cycle.
  - Then go to WAIT_LO_HI.
- WAIT_LO_HI waits for TX_BUSY high, then goes to WAIT_LO_LO. WAIT_LO_LO waits for TX_BUSY low, then goes to SEND_HI.
- SEND_HI, WAIT_HI_HI, WAIT_HI_LO: same sequence with result[15:8]; WAIT_HI_LO returns to IDLE.
- RX_D_VLD in any state from ALU_RUN through WAIT_HI_LO: the byte is dropped silently. No CMD_ERR, no state change.
- ALU_A and ALU_B persist across commands and are only rewritten by a 0xCC frame. Operand width and sign handling belong to the ALU; this block forwards raw bytes.
- TX_P_DATA holds its last value between requests.

## Timing
- Reset values: ALU_A=0, ALU_B=0, ALU_FUN=ADD, ALU_EN=0, TX_P_DATA=0, TX_D_VLD=0, BUSY=0, CMD_ERR=0, result register 0, state IDLE.
- Reset asserted mid-frame or mid-transmit aborts immediately. All outputs take their reset values with no partial byte request. The host must resend the frame.
- All outputs are registered; no combinational path from input to output.
- Last frame byte to ALU_EN: 1 cycle (GET_FUN→ALU_RUN). ALU_EN to result capture: 2 cycles with a registered ALU. WAIT_RES has no timeout.
- TX_D_VLD is never asserted while TX_BUSY is high. Two requests are always separated by an observed TX_BUSY rise and fall.
- Simultaneous RX_D_VLD and TX activity during SEND/WAIT: RX is ignored; TX sequencing is unaffected.

## Structure
- alu_pkg holds:
  - alu_op_e (4-bit, encoding above);
  - the ctrl_state_e FSM enum;
  - CMD_ALU_OP and CMD_ALU_NOP default localparams;
  - the FUN_MAX=14 constant.
- One sub-module, tx_byte_seq, is natural. It takes a 16-bit word plus a start strobe and runs the two-byte SEND/WAIT handshake against TX_BUSY, returning done. The top FSM then ends at WAIT_RES.

## Test plan
- ADD frame: CC,12,34,00 → ALU_EN one cycle with A=0x12, B=0x34, FUN=ADD. ALU returns 0x0046 → TX bytes 0x46 then 0x00; BUSY low afterwards.
- MUL frame: CC,FF,FF,02 → ALU result 0xFE01 → TX_P_DATA 0x01 then 0xFE. Second TX_D_VLD only after TX_BUSY falls; hold TX_BUSY high 200 cycles and check there is no early request.
- Reuse frame after the ADD frame: DD,01 → ALU_EN with A=0x12, B=0x34, FUN=SUB. ALU returns 0xFFDE → TX bytes 0xDE, 0xFF.
- Errors:
  - 0x55 in IDLE → one CMD_ERR pulse, state IDLE.
  - CC,01,02,0F → CMD_ERR pulse, no ALU_EN, no TX.
- Extra RX bytes (0xAA) injected during WAIT_RES and SEND_HI → ignored. Output bytes and ordering unchanged; no CMD_ERR.
- RST low in WAIT_LO_LO → all outputs at reset values within the same cycle. The next frame CC,03,04,00 is processed normally.
